ahb_bus_arbiter: RTL and testbench



---
 rtl/ahb_bus_arbiter.sv | 151 +++++++++++++++
 tb/tb_ahb_bus_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ahb_bus_arbiter.sv
// rtl/ahb_bus_arbiter.sv - round-robin AHB arbiter for four masters sharing the APB bridge port
//
// Purpose:
//   Grants the single AHB-to-APB bridge slave port to one of four masters in
//   round-robin order. Ownership moves only on HREADY-qualified edges. A
//   per-tenure beat limit stops one master from holding the bus for a long
//   burst while others wait. Locked sequences are never interrupted.
//
// Ports:
//   HCLK       in   1  bus clock, rising edge
//   HRESETn    in   1  asynchronous active-low reset
//   HBUSREQ    in   4  per-master bus request
//   HLOCK      in   4  per-master locked-transfer request
//   HTRANS     in   2  transfer type of the address-phase owner (muxed bus)
//   HREADY     in   1  transfer complete from the bridge
//   HGRANT     out  4  one-hot grant, registered
//   HMASTER    out  2  index of the address-phase owner, registered
//   HMASTLOCK  out  1  current transfer is locked, registered

module ahb_bus_arbiter #(
    parameter int         NUM_MASTERS    = 4,
    parameter logic [1:0] DEFAULT_MASTER = 2'd0,
    parameter int         MAX_BEATS      = 8
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic [1:0]             HTRANS,
    input  logic                   HREADY,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [1:0]             HMASTER,
    output logic                   HMASTLOCK
);

    typedef enum logic [1:0] {
        ARB_PARK = 2'd0,
        ARB_OWN  = 2'd1,
        ARB_LOCK = 2'd2
    } arb_state_t;

    localparam logic [7:0]             MAX_CNT      = 8'(MAX_BEATS);
    localparam logic [NUM_MASTERS-1:0] DEFAULT_HOT  = NUM_MASTERS'(1) << DEFAULT_MASTER;

    arb_state_t state;
    arb_state_t nxt_state;
    logic [7:0] beat_cnt;

    logic [1:0] g;
    logic [1:0] rr_win;
    logic       rr_any;
    logic       others_req;
    logic [1:0] nxt_idx;
    logic       tenure_clr;

    // Only HTRANS[1] distinguishes NONSEQ/SEQ from IDLE/BUSY.
    logic unused_htrans0;
    assign unused_htrans0 = HTRANS[0];

    // Encode the grant; any non-one-hot pattern is treated as the parked master.
    always_comb begin
        g = DEFAULT_MASTER;
        case (HGRANT)
            4'b0001: g = 2'd0;
            4'b0010: g = 2'd1;
            4'b0100: g = 2'd2;
            4'b1000: g = 2'd3;
            default: g = DEFAULT_MASTER;
        endcase
    end

    // Round-robin search from g+1 upward. Iterating from the far end down
    // means the nearest requester is assigned last and wins; g itself sits at
    // distance 4 so it wins only when it is the sole requester.
    always_comb begin
        rr_win = g;
        rr_any = 1'b0;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            if (HBUSREQ[g + 2'(i)]) begin
                rr_win = g + 2'(i);
                rr_any = 1'b1;
            end
        end
    end

    assign others_req = |(HBUSREQ & ~HGRANT);

    always_comb begin
        nxt_idx    = g;
        nxt_state  = state;
        tenure_clr = 1'b0;
        if (state == ARB_PARK) begin
            if (rr_any) begin
                nxt_idx   = rr_win;
                nxt_state = HLOCK[rr_win] ? ARB_LOCK : ARB_OWN;
            end else begin
                nxt_idx = DEFAULT_MASTER;
            end
        end else if (state == ARB_LOCK && HLOCK[g]) begin
            // Locked sequence: grant frozen, tenure limit ignored.
            nxt_idx   = g;
            nxt_state = ARB_LOCK;
        end else begin
            // Owner evaluation, also used on the edge a lock is released.
            if (!HBUSREQ[g]) begin
                if (others_req) begin
                    nxt_idx   = rr_win;
                    nxt_state = HLOCK[rr_win] ? ARB_LOCK : ARB_OWN;
                end else begin
                    nxt_idx   = DEFAULT_MASTER;
                    nxt_state = ARB_PARK;
                end
            end else if (HLOCK[g]) begin
                nxt_state = ARB_LOCK;
            end else if (beat_cnt == MAX_CNT) begin
                if (others_req) begin
                    nxt_idx   = rr_win;
                    nxt_state = HLOCK[rr_win] ? ARB_LOCK : ARB_OWN;
                end else begin
                    // Nobody waiting: keep the bus and start a fresh tenure.
                    tenure_clr = 1'b1;
                    nxt_state  = ARB_OWN;
                end
            end else begin
                nxt_state = ARB_OWN;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= ARB_PARK;
            HGRANT    <= DEFAULT_HOT;
            HMASTER   <= DEFAULT_MASTER;
            HMASTLOCK <= 1'b0;
            beat_cnt  <= 8'd0;
        end else if (HREADY) begin
            state     <= nxt_state;
            HGRANT    <= NUM_MASTERS'(1) << nxt_idx;
            // Data phase follows address phase by one transfer.
            HMASTER   <= g;
            HMASTLOCK <= HLOCK[g] & HBUSREQ[g];
            if (nxt_idx != g || tenure_clr) begin
                beat_cnt <= 8'd0;
            end else if (HTRANS[1] && beat_cnt != MAX_CNT) begin
                beat_cnt <= beat_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb/tb_ahb_bus_arbiter.sv - directed self-checking bench for ahb_bus_arbiter

module tb_ahb_bus_arbiter;

    logic       HCLK;
    logic       HRESETn;
    logic [3:0] HBUSREQ;
    logic [3:0] HLOCK;
    logic [1:0] HTRANS;
    logic       HREADY;
    logic [3:0] HGRANT;
    logic [1:0] HMASTER;
    logic       HMASTLOCK;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;

    ahb_bus_arbiter #(
        .NUM_MASTERS   (4),
        .DEFAULT_MASTER(2'd0),
        .MAX_BEATS     (8)
    ) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .HBUSREQ  (HBUSREQ),
        .HLOCK    (HLOCK),
        .HTRANS   (HTRANS),
        .HREADY   (HREADY),
        .HGRANT   (HGRANT),
        .HMASTER  (HMASTER),
        .HMASTLOCK(HMASTLOCK)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic check_out(input string tag, input logic [3:0] grant,
                             input logic [1:0] master, input logic lock);
        check({tag, ".grant"}, 32'(HGRANT), 32'(grant));
        check({tag, ".master"}, 32'(HMASTER), 32'(master));
        check({tag, ".lock"}, 32'(HMASTLOCK), 32'(lock));
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        tick();
        tick();
        HRESETn = 1'b1;
    endtask

    initial begin
        int owner;
        int cnt;

        HRESETn = 1'b0;
        HBUSREQ = 4'b0000;
        HLOCK   = 4'b0000;
        HTRANS  = T_IDLE;
        HREADY  = 1'b1;
        do_reset();

        // Reset state and idle parking
        check_out("reset", 4'b0001, 2'd0, 1'b0);
        check("reset.beat", 32'(dut.beat_cnt), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_out("park", 4'b0001, 2'd0, 1'b0);
        end

        // Round-robin from park: 1 and 2 request, 1 wins first
        HBUSREQ = 4'b0110;
        tick();
        check_out("rr_first", 4'b0010, 2'd0, 1'b0);
        tick();
        check_out("rr_hold", 4'b0010, 2'd1, 1'b0);
        HBUSREQ = 4'b0100;
        tick();
        check_out("rr_drop", 4'b0100, 2'd1, 1'b0);

        // Wait states freeze handover
        HREADY  = 1'b0;
        HBUSREQ = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("wait_hold", 4'b0100, 2'd1, 1'b0);
        end
        HREADY = 1'b1;
        tick();
        check_out("wait_release", 4'b1000, 2'd2, 1'b0);

        // Tenure limit alternation between masters 0 and 1
        HBUSREQ = 4'b0011;
        HTRANS  = T_NONSEQ;
        tick();
        check("tenure_start.grant", 32'(HGRANT), 32'h1);
        owner = 0;
        cnt   = 0;
        for (int i = 0; i < 27; i++) begin
            tick();
            if (cnt == 8) begin
                owner = 1 - owner;
                cnt   = 0;
            end else begin
                cnt++;
            end
            check("tenure.grant", 32'(HGRANT), 32'(1 << owner));
            check("tenure.beat", 32'(dut.beat_cnt), 32'(cnt));
        end

        // Locked tenure: master 1 holds despite master 2 waiting
        do_reset();
        HBUSREQ = 4'b0110;
        HLOCK   = 4'b0010;
        HTRANS  = T_NONSEQ;
        tick();
        check_out("lock_enter", 4'b0010, 2'd0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            check_out("lock_hold", 4'b0010, 2'd1, 1'b1);
        end
        check("lock_sat.beat", 32'(dut.beat_cnt), 32'd8);
        HLOCK = 4'b0000;
        tick();
        check_out("lock_exit", 4'b0100, 2'd1, 1'b0);
        check("lock_exit.beat", 32'(dut.beat_cnt), 32'd0);

        // BUSY does not count; limit with nobody waiting keeps grant
        HBUSREQ = 4'b0100;
        HTRANS  = T_BUSY;
        tick();
        check("busy.beat", 32'(dut.beat_cnt), 32'd0);
        check_out("busy", 4'b0100, 2'd2, 1'b0);
        HTRANS = T_NONSEQ;
        for (int i = 0; i < 8; i++) tick();
        check("solo_limit.beat", 32'(dut.beat_cnt), 32'd8);
        check("solo_limit.grant", 32'(HGRANT), 32'h4);
        tick();
        check("solo_keep.beat", 32'(dut.beat_cnt), 32'd0);
        check("solo_keep.grant", 32'(HGRANT), 32'h4);

        // Asynchronous reset mid-burst with master 3 owning
        HBUSREQ = 4'b1000;
        tick();
        check("m3.grant", 32'(HGRANT), 32'h8);
        tick();
        tick();
        check("m3.beat", 32'(dut.beat_cnt), 32'd2);
        check("m3.master", 32'(HMASTER), 32'd3);
        HREADY = 1'b0;
        #2;
        HRESETn = 1'b0;
        #1;
        check_out("async_rst", 4'b0001, 2'd0, 1'b0);
        check("async_rst.beat", 32'(dut.beat_cnt), 32'd0);
        #2;
        HRESETn = 1'b1;
        HREADY  = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
